// File: rtl/pc_pkg.sv
// pc_pkg: shared fetch-state encoding and default widths for the TinyGPU fetch unit
package pc_pkg;
  localparam int PC_WIDTH = 8;
  localparam int INSTR_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FETCHING = 2'b01,
    FETCHED  = 2'b10,
    DONE     = 2'b11
  } fetch_state_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: valid/ready program-memory read bus
//   master (fetch unit): drives MemReadValid, MemReadAddress; receives MemReadReady, MemReadData
//   slave  (memory):     the mirror image
interface pc_fetch_unit_if #(
  parameter int AW = pc_pkg::PC_WIDTH,
  parameter int DW = pc_pkg::INSTR_WIDTH
);
  logic          MemReadValid;
  logic [AW-1:0] MemReadAddress;
  logic          MemReadReady;
  logic [DW-1:0] MemReadData;
  modport master (output MemReadValid, MemReadAddress, input MemReadReady, MemReadData);
  modport slave  (input MemReadValid, MemReadAddress, output MemReadReady, MemReadData);
endinterface

// File: rtl/pc_reg.sv
// pc_reg: program-counter register
//   clk, reset (async, active high, clears to 0)
//   clr_i: synchronous clear, wins over ld_i
//   ld_i/d_i: load d_i unmodified; q_o: current PC
module pc_reg #(
  parameter int W = pc_pkg::PC_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pc_q, pc_d;
  always_comb pc_d = clr_i ? '0 : ld_i ? d_i : pc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= '0;
    else pc_q <= pc_d;
  assign q_o = pc_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register plus single-outstanding instruction-fetch FSM
//   clk, reset (async, active high)
//   Start: sync restart (PC=0, IDLE); FetchReq: fetch at CurrentPC
//   PCUpdate/HaltReq/NextPC: commit next PC in FETCHED, optionally halting
//   CurrentPC, CurrentPCPlus: PC and PC+1 (wraps) to the PC mux
//   mem: program-memory read bus (master side)
//   Instruction, InstrValid: captured word for decode; Done: core halted
module pc_fetch_unit #(
  parameter int PC_WIDTH = pc_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = pc_pkg::INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic                   FetchReq,
  input  logic                   PCUpdate,
  input  logic                   HaltReq,
  input  logic [PC_WIDTH-1:0]    NextPC,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic [PC_WIDTH-1:0]    CurrentPCPlus,
  pc_fetch_unit_if.master        mem,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  output logic                   Done
);
  import pc_pkg::*;
  fetch_state_t state_q, state_d;
  logic valid_q, valid_d, ivalid_q, ivalid_d, done_q, done_d, pc_ld;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  pc_reg #(.W(PC_WIDTH)) u_pc (
    .clk(clk), .reset(reset), .clr_i(Start), .ld_i(pc_ld), .d_i(NextPC), .q_o(CurrentPC)
  );
  assign CurrentPCPlus = CurrentPC + 1'b1;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d = addr_q;
    instr_d = instr_q;
    ivalid_d = ivalid_q;
    done_d = done_q;
    pc_ld = 1'b0;
    if (Start) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ivalid_d = 1'b0;
      done_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (FetchReq) begin
          state_d = FETCHING;
          addr_d = CurrentPC;
          valid_d = 1'b1;
        end
        FETCHING: if (mem.MemReadReady) begin
          state_d = FETCHED;
          instr_d = mem.MemReadData;
          ivalid_d = 1'b1;
          valid_d = 1'b0;
        end
        FETCHED: if (PCUpdate) begin
          pc_ld = 1'b1;
          ivalid_d = 1'b0;
          done_d = HaltReq;
          state_d = HaltReq ? DONE : IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q <= '0;
      instr_q <= '0;
      ivalid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      ivalid_q <= ivalid_d;
      done_q <= done_d;
    end
  assign mem.MemReadValid = valid_q;
  assign mem.MemReadAddress = addr_q;
  assign Instruction = instr_q;
  assign InstrValid = ivalid_q;
  assign Done = done_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic Start = 1'b0, FetchReq = 1'b0, PCUpdate = 1'b0, HaltReq = 1'b0;
  logic [7:0] NextPC = '0;
  logic [7:0] CurrentPC, CurrentPCPlus;
  logic [15:0] Instruction;
  logic InstrValid, Done;
  int n_cmp = 0, n_err = 0;
  pc_fetch_unit_if #(.AW(8), .DW(16)) mem ();
  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .FetchReq(FetchReq), .PCUpdate(PCUpdate),
    .HaltReq(HaltReq), .NextPC(NextPC), .CurrentPC(CurrentPC), .CurrentPCPlus(CurrentPCPlus),
    .mem(mem), .Instruction(Instruction), .InstrValid(InstrValid), .Done(Done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic fetch_ok(input logic [15:0] d);
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    mem.MemReadReady = 1'b1;
    mem.MemReadData = d;
    tick();
    mem.MemReadReady = 1'b0;
  endtask
  initial begin
    mem.MemReadReady = 1'b0;
    mem.MemReadData = '0;
    #12;
    chk("rst_pc", CurrentPC, 8'h00);
    chk("rst_pcplus", CurrentPCPlus, 8'h01);
    chk("rst_valid", mem.MemReadValid, 1'b0);
    chk("rst_addr", mem.MemReadAddress, 8'h00);
    chk("rst_instr", Instruction, 16'h0000);
    chk("rst_ivalid", InstrValid, 1'b0);
    chk("rst_done", Done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    // ready while idle is ignored
    mem.MemReadReady = 1'b1;
    mem.MemReadData = 16'hDEAD;
    tick();
    mem.MemReadReady = 1'b0;
    chk("idle_ready_ivalid", InstrValid, 1'b0);
    chk("idle_ready_instr", Instruction, 16'h0000);
    // basic fetch, ready in first valid cycle
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    chk("f1_valid", mem.MemReadValid, 1'b1);
    chk("f1_addr", mem.MemReadAddress, 8'h00);
    chk("f1_ivalid_early", InstrValid, 1'b0);
    mem.MemReadReady = 1'b1;
    mem.MemReadData = 16'h1234;
    tick();
    mem.MemReadReady = 1'b0;
    chk("f1_ivalid", InstrValid, 1'b1);
    chk("f1_instr", Instruction, 16'h1234);
    chk("f1_valid_drop", mem.MemReadValid, 1'b0);
    // commit NextPC
    PCUpdate = 1'b1;
    NextPC = 8'h3C;
    tick();
    PCUpdate = 1'b0;
    chk("upd_pc", CurrentPC, 8'h3C);
    chk("upd_pcplus", CurrentPCPlus, 8'h3D);
    chk("upd_ivalid", InstrValid, 1'b0);
    // PCUpdate in IDLE ignored
    PCUpdate = 1'b1;
    NextPC = 8'h55;
    tick();
    PCUpdate = 1'b0;
    chk("idle_upd_pc", CurrentPC, 8'h3C);
    // memory stalls 5 cycles
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", mem.MemReadValid, 1'b1);
      chk("stall_addr", mem.MemReadAddress, 8'h3C);
      chk("stall_ivalid", InstrValid, 1'b0);
      tick();
    end
    mem.MemReadReady = 1'b1;
    mem.MemReadData = 16'hA5A5;
    tick();
    mem.MemReadReady = 1'b0;
    chk("stall_cap_ivalid", InstrValid, 1'b1);
    chk("stall_cap_instr", Instruction, 16'hA5A5);
    mem.MemReadReady = 1'b1;
    mem.MemReadData = 16'h5A5A;
    tick();
    mem.MemReadReady = 1'b0;
    chk("fetched_hold_instr", Instruction, 16'hA5A5);
    chk("fetched_hold_ivalid", InstrValid, 1'b1);
    // wrap
    PCUpdate = 1'b1;
    NextPC = 8'hFF;
    tick();
    PCUpdate = 1'b0;
    chk("wrap_pc", CurrentPC, 8'hFF);
    chk("wrap_pcplus", CurrentPCPlus, 8'h00);
    fetch_ok(16'h0F0F);
    chk("wrap_fetch_addr", mem.MemReadAddress, 8'hFF);
    PCUpdate = 1'b1;
    NextPC = 8'h00;
    tick();
    PCUpdate = 1'b0;
    chk("wrap0_pc", CurrentPC, 8'h00);
    chk("wrap0_pcplus", CurrentPCPlus, 8'h01);
    // halt
    fetch_ok(16'h2222);
    HaltReq = 1'b1;
    PCUpdate = 1'b1;
    NextPC = 8'h10;
    tick();
    HaltReq = 1'b0;
    PCUpdate = 1'b0;
    chk("halt_done", Done, 1'b1);
    chk("halt_pc", CurrentPC, 8'h10);
    chk("halt_ivalid", InstrValid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      FetchReq = 1'b1;
      tick();
      chk("done_no_valid", mem.MemReadValid, 1'b0);
    end
    FetchReq = 1'b0;
    PCUpdate = 1'b1;
    NextPC = 8'h77;
    tick();
    PCUpdate = 1'b0;
    chk("done_upd_pc", CurrentPC, 8'h10);
    chk("done_stays", Done, 1'b1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_done", Done, 1'b0);
    chk("start_pc", CurrentPC, 8'h00);
    // Start collides with MemReadReady in FETCHING
    fetch_ok(16'h3333);
    PCUpdate = 1'b1;
    NextPC = 8'h20;
    tick();
    PCUpdate = 1'b0;
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    chk("sf_addr", mem.MemReadAddress, 8'h20);
    Start = 1'b1;
    mem.MemReadReady = 1'b1;
    mem.MemReadData = 16'hBEEF;
    tick();
    Start = 1'b0;
    mem.MemReadReady = 1'b0;
    chk("sf_valid", mem.MemReadValid, 1'b0);
    chk("sf_ivalid", InstrValid, 1'b0);
    chk("sf_instr", Instruction, 16'h3333);
    chk("sf_pc", CurrentPC, 8'h00);
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    chk("sf_idle_refetch", mem.MemReadValid, 1'b1);
    // async reset mid-wait
    tick();
    chk("ar_pre_valid", mem.MemReadValid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", mem.MemReadValid, 1'b0);
    chk("ar_pc", CurrentPC, 8'h00);
    chk("ar_instr", Instruction, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    chk("ar_refetch", mem.MemReadValid, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
